// File: rtl/multicycle_control_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_control_pkg
// Shared definitions for the multicycle controller:
//   - state encodings (visible on the state output, so they are fixed values)
//   - instruction opcodes (instruction[15:12])
//   - alu_op function codes and pc_src selector codes
//   - instruction class enum and the decoder result struct
//   - the memory wait limit used by the stall watchdog
// ---------------------------------------------------------------------------
package multicycle_control_pkg;

  // Controller state encodings.
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_FAULT  = 3'd5;

  // Opcodes; every other value is illegal.
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLT = 4'b0100;
  localparam logic [3:0] OP_LW  = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SW  = 4'b1010;
  localparam logic [3:0] OP_BNE = 4'b1110;
  localparam logic [3:0] OP_JMP = 4'b1111;

  // ALU function codes.
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // PC source selector codes.
  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;  // PC + 2
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;  // branch target
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;  // jump target

  // Consecutive not-ready cycles tolerated before the watchdog trips.
  localparam logic [3:0] WAIT_LIMIT = 4'd15;

  // Instruction classes that steer the state sequence.
  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_LW  = 3'd1,
    CLS_SW  = 3'd2,
    CLS_BNE = 3'd3,
    CLS_JMP = 3'd4
  } instr_class_e;

  // Result of decoding one opcode.
  typedef struct packed {
    logic         legal;
    instr_class_e cls;
    logic [2:0]   alu_op;
  } decode_t;

  // States in which the controller is waiting on the memory handshake.
  function automatic logic is_mem_wait_state(input logic [2:0] st);
    return (st == ST_FETCH) || (st == ST_MEM);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_if
// Bundles the controller <-> datapath signals.
//   datapath -> controller : opcode[3:0], eq, mem_ready
//   controller -> datapath : imem_req, ir_write, pc_write, pc_src[1:0],
//                            reg_dst, reg_write, alu_src, mem_read,
//                            mem_write, mem_to_reg, alu_op[2:0]
//   controller status      : state[2:0], illegal, retired[15:0]
// Modports:
//   master - the controller (drives strobes and status)
//   slave  - the datapath side (drives opcode / eq / mem_ready)
// ---------------------------------------------------------------------------
interface multicycle_control_if;

  // Datapath to controller.
  logic [3:0]  opcode;
  logic        eq;
  logic        mem_ready;

  // Controller strobes.
  logic        imem_req;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        reg_dst;
  logic        reg_write;
  logic        alu_src;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic [2:0]  alu_op;

  // Controller status.
  logic [2:0]  state;
  logic        illegal;
  logic [15:0] retired;

  modport master (
    input  opcode, eq, mem_ready,
    output imem_req, ir_write, pc_write, pc_src, reg_dst, reg_write,
           alu_src, mem_read, mem_write, mem_to_reg, alu_op,
           state, illegal, retired
  );

  modport slave (
    output opcode, eq, mem_ready,
    input  imem_req, ir_write, pc_write, pc_src, reg_dst, reg_write,
           alu_src, mem_read, mem_write, mem_to_reg, alu_op,
           state, illegal, retired
  );

endinterface

// File: rtl/multicycle_control_opcode_decoder.sv
// ---------------------------------------------------------------------------
// opcode_decoder
// Purely combinational map from a 4-bit opcode to:
//   dec.legal  - opcode is one of the supported instructions
//   dec.cls    - instruction class (R, LW, SW, BNE, JMP)
//   dec.alu_op - ALU function used during EXEC / MEM
// Ports:
//   opcode [3:0] in  - latched instruction[15:12]
//   dec          out - decode_t result
// Illegal opcodes report legal = 0 with a harmless R / AND payload; the
// controller never uses the payload in that case.
// ---------------------------------------------------------------------------
module opcode_decoder
  import multicycle_control_pkg::*;
(
  input  logic [3:0] opcode,
  output decode_t    dec
);

  always_comb begin
    dec = '{legal: 1'b0, cls: CLS_R, alu_op: ALU_AND};
    case (opcode)
      OP_AND: dec = '{legal: 1'b1, cls: CLS_R,   alu_op: ALU_AND};
      OP_OR:  dec = '{legal: 1'b1, cls: CLS_R,   alu_op: ALU_OR};
      OP_ADD: dec = '{legal: 1'b1, cls: CLS_R,   alu_op: ALU_ADD};
      OP_SUB: dec = '{legal: 1'b1, cls: CLS_R,   alu_op: ALU_SUB};
      OP_SLT: dec = '{legal: 1'b1, cls: CLS_R,   alu_op: ALU_SLT};
      // Loads and stores use the adder for address generation.
      OP_LW:  dec = '{legal: 1'b1, cls: CLS_LW,  alu_op: ALU_ADD};
      OP_SW:  dec = '{legal: 1'b1, cls: CLS_SW,  alu_op: ALU_ADD};
      // The branch compares by subtraction; eq comes back from the ALU.
      OP_BNE: dec = '{legal: 1'b1, cls: CLS_BNE, alu_op: ALU_SUB};
      OP_JMP: dec = '{legal: 1'b1, cls: CLS_JMP, alu_op: ALU_AND};
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Control FSM for a multicycle 16-bit processor.
// Sequence: FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH, with FAULT as
// a sticky trap for illegal opcodes and memory stalls that never resolve.
// Ports:
//   clock - rising-edge system clock
//   clear - asynchronous active-high reset
//   bus   - multicycle_control_if.master (opcode/eq/mem_ready in, datapath
//           strobes, state, illegal and retired count out)
// All strobes are a combinational decode of the current state and the
// opcode latched when leaving FETCH (plus mem_ready / eq where a strobe is
// qualified by them). Strobes are gated by clear so they drop immediately
// when reset is asserted, without waiting for a clock edge.
// ---------------------------------------------------------------------------
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic                    clock,
  input  logic                    clear,
  multicycle_control_if.master    bus
);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [2:0]  state_q,   state_d;
  logic [3:0]  opcode_q,  opcode_d;
  logic [3:0]  wait_q,    wait_d;
  logic [15:0] retired_q, retired_d;
  logic        illegal_q, illegal_d;
  logic        retire;

  decode_t     dec;

  opcode_decoder u_opcode_decoder (
    .opcode (opcode_q),
    .dec    (dec)
  );

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    retire   = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (bus.mem_ready) begin
          state_d  = ST_DECODE;
          opcode_d = bus.opcode;
        end else if (wait_q == WAIT_LIMIT) begin
          state_d = ST_FAULT;
        end
      end

      ST_DECODE: begin
        if (!dec.legal) begin
          state_d = ST_FAULT;
        end else if (dec.cls == CLS_JMP) begin
          state_d = ST_FETCH;
          retire  = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        case (dec.cls)
          CLS_R:          state_d = ST_WB;
          CLS_LW, CLS_SW: state_d = ST_MEM;
          CLS_BNE: begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end
          // JMP never reaches EXEC; treat it as corruption.
          default:        state_d = ST_FAULT;
        endcase
      end

      ST_MEM: begin
        if (bus.mem_ready) begin
          if (dec.cls == CLS_LW) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end
        end else if (wait_q == WAIT_LIMIT) begin
          state_d = ST_FAULT;
        end
      end

      ST_WB: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end

      ST_FAULT: state_d = ST_FAULT;

      // Unused encodings fall into the trap rather than wandering.
      default:  state_d = ST_FAULT;
    endcase
  end

  // Wait counter tracks consecutive not-ready cycles in the current memory
  // wait. Any state change restarts it, so it never wraps: at WAIT_LIMIT
  // the FSM leaves for FAULT, which itself clears the count.
  always_comb begin
    if ((state_d != state_q) || bus.mem_ready) begin
      wait_d = 4'd0;
    end else if (is_mem_wait_state(state_q)) begin
      wait_d = wait_q + 4'd1;
    end else begin
      wait_d = 4'd0;
    end
  end

  always_comb begin
    retired_d = retired_q + {15'd0, retire};   // wraps naturally at 16 bits
    illegal_d = illegal_q | (state_d == ST_FAULT);
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q   <= ST_FETCH;
      opcode_q  <= OP_AND;
      wait_q    <= 4'd0;
      retired_q <= 16'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  // ---------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------
  logic       imem_req;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src;
  logic       mem_read;
  logic       mem_write;
  logic       mem_to_reg;
  logic [2:0] alu_op;

  always_comb begin
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_SEQ;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_op     = ALU_AND;

    // state_q already reads FETCH during clear; the gate also silences the
    // FETCH request so nothing reaches memory while reset is held.
    if (!clear) begin
      case (state_q)
        ST_FETCH: begin
          imem_req = 1'b1;
          if (bus.mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            pc_src   = PC_SRC_SEQ;
          end
        end

        ST_DECODE: begin
          if (dec.legal && (dec.cls == CLS_JMP)) begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_JUMP;
          end
        end

        ST_EXEC: begin
          alu_op = dec.alu_op;
          case (dec.cls)
            CLS_R:          reg_dst = 1'b1;
            CLS_LW, CLS_SW: alu_src = 1'b1;
            CLS_BNE: begin
              // Branch taken when the operands differ.
              if (!bus.eq) begin
                pc_write = 1'b1;
                pc_src   = PC_SRC_BRANCH;
              end
            end
            default: ;
          endcase
        end

        ST_MEM: begin
          alu_op = dec.alu_op;
          // Held for the whole access, including the ready cycle.
          if (dec.cls == CLS_LW) begin
            mem_read = 1'b1;
          end else if (dec.cls == CLS_SW) begin
            mem_write = 1'b1;
          end
        end

        ST_WB: begin
          reg_write = 1'b1;
          if (dec.cls == CLS_LW) begin
            mem_to_reg = 1'b1;       // loads target instruction[11:8]
          end else begin
            reg_dst    = 1'b1;       // R-type targets instruction[7:4]
          end
        end

        default: ;                   // FAULT: everything quiet
      endcase
    end
  end

  assign bus.imem_req   = imem_req;
  assign bus.ir_write   = ir_write;
  assign bus.pc_write   = pc_write;
  assign bus.pc_src     = pc_src;
  assign bus.reg_dst    = reg_dst;
  assign bus.reg_write  = reg_write;
  assign bus.alu_src    = alu_src;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.alu_op     = alu_op;
  assign bus.state      = state_q;
  assign bus.illegal    = illegal_q;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
// Directed bench for multicycle_control. Each cycle drives mem_ready / eq /
// opcode just after the falling edge and compares a packed view of
// {state, strobes, alu_op} against a hand-computed expectation.
// Packed view field order:
//   state[2:0] imem_req ir_write pc_write pc_src[1:0] reg_dst reg_write
//   alu_src mem_read mem_write mem_to_reg alu_op[2:0]
// ---------------------------------------------------------------------------
module tb_multicycle_control;

  logic clock = 1'b0;
  logic clear;

  always #5 clock = ~clock;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  function automatic logic [16:0] mk(input int st, input int imem, input int ir,
                                     input int pcw, input int pcs, input int rdst,
                                     input int rw, input int asrc, input int mr,
                                     input int mw, input int m2r, input int alu);
    return {st[2:0], imem[0], ir[0], pcw[0], pcs[1:0], rdst[0], rw[0],
            asrc[0], mr[0], mw[0], m2r[0], alu[2:0]};
  endfunction

  function automatic logic [16:0] outs();
    return {bus.state, bus.imem_req, bus.ir_write, bus.pc_write, bus.pc_src,
            bus.reg_dst, bus.reg_write, bus.alu_src, bus.mem_read,
            bus.mem_write, bus.mem_to_reg, bus.alu_op};
  endfunction

  // One clock cycle: drive inputs after the falling edge, then check.
  task automatic cyc(input string tag, input logic rdy, input logic e,
                     input logic [3:0] op, input logic [16:0] exp);
    @(negedge clock);
    bus.mem_ready = rdy;
    bus.eq        = e;
    bus.opcode    = op;
    #1;
    check(tag, {15'd0, outs()}, {15'd0, exp});
  endtask

  logic [16:0] f_take;   // FETCH with mem_ready = 1
  logic [16:0] f_idle;   // FETCH waiting
  logic [16:0] quiet;    // all zero in a given state is built with mk()

  initial begin
    f_take = mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    f_idle = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    quiet  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    clear         = 1'b1;
    bus.mem_ready = 1'b0;
    bus.eq        = 1'b0;
    bus.opcode    = 4'h0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset outs", {15'd0, outs()}, {15'd0, quiet});
    check("reset retired", {16'd0, bus.retired}, 32'd0);
    check("reset illegal", {31'd0, bus.illegal}, 32'd0);
    @(posedge clock);
    #2 clear = 1'b0;

    // ADD then SUB, zero wait; the opcode bus carries junk after fetch.
    cyc("add fetch",  1, 0, 4'h2, f_take);
    cyc("add decode", 1, 0, 4'h3, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("add exec",   1, 0, 4'h3, mk(2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2));
    cyc("add wb",     1, 0, 4'h3, mk(4, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    cyc("sub fetch",  1, 0, 4'h6, f_take);
    cyc("sub decode", 1, 0, 4'h3, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("sub exec",   1, 0, 4'h3, mk(2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3));
    cyc("sub wb",     1, 0, 4'h3, mk(4, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    cyc("idle fetch", 0, 0, 4'h0, f_idle);
    check("retired after add/sub", {16'd0, bus.retired}, 32'd2);

    // LW with three not-ready MEM cycles.
    cyc("lw fetch",  1, 0, 4'h5, f_take);
    cyc("lw decode", 0, 0, 4'h0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("lw exec",   0, 0, 4'h0, mk(2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2));
    for (int i = 1; i <= 3; i++)
      cyc($sformatf("lw mem wait%0d", i), 0, 0, 4'h0, mk(3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2));
    cyc("lw mem ready", 1, 0, 4'h0, mk(3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2));
    cyc("lw wb",        0, 0, 4'h0, mk(4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));

    // BNE taken (eq = 0) then not taken (eq = 1, stray mem_ready in EXEC).
    cyc("bne0 fetch",  1, 0, 4'hE, f_take);
    check("retired after lw", {16'd0, bus.retired}, 32'd3);
    cyc("bne0 decode", 0, 0, 4'h0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("bne0 exec",   0, 0, 4'h0, mk(2, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 3));
    cyc("bne1 fetch",  1, 1, 4'hE, f_take);
    cyc("bne1 decode", 0, 1, 4'h0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("bne1 exec",   1, 1, 4'h0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));

    // JMP: two cycles.
    cyc("jmp fetch",  1, 0, 4'hF, f_take);
    check("retired after bne", {16'd0, bus.retired}, 32'd5);
    cyc("jmp decode", 0, 0, 4'h0, mk(1, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0));
    cyc("after jmp",  0, 0, 4'h0, f_idle);
    check("retired after jmp", {16'd0, bus.retired}, 32'd6);

    // Preset retired to FFFF, then one SW retire wraps it to 0000.
    force dut.retired_d = 16'hFFFF;
    @(posedge clock);
    #1 release dut.retired_d;
    cyc("sw fetch",  1, 0, 4'hA, f_take);
    check("retired preset", {16'd0, bus.retired}, 32'h0000FFFF);
    cyc("sw decode", 0, 0, 4'h0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("sw exec",   0, 0, 4'h0, mk(2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2));
    cyc("sw mem wait",  0, 0, 4'h0, mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2));
    cyc("sw mem ready", 1, 0, 4'h0, mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2));
    cyc("sw2 fetch",  1, 0, 4'hA, f_take);
    check("retired wrap", {16'd0, bus.retired}, 32'd0);
    cyc("sw2 decode", 0, 0, 4'h0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("sw2 exec",   0, 0, 4'h0, mk(2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2));
    cyc("sw2 mem",    0, 0, 4'h0, mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2));

    // Clear mid-MEM: outputs must fall before the next rising edge.
    #1 clear = 1'b1;
    #1;
    check("clear async outs", {15'd0, outs()}, {15'd0, quiet});
    check("clear async retired", {16'd0, bus.retired}, 32'd0);
    @(posedge clock);
    #2 clear = 1'b0;

    // Illegal opcode 0011 traps in FAULT until clear.
    cyc("bad fetch",  1, 0, 4'h3, f_take);
    cyc("bad decode", 0, 0, 4'h0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check("illegal before fault", {31'd0, bus.illegal}, 32'd0);
    cyc("bad fault",  1, 0, 4'h0, mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check("illegal in fault", {31'd0, bus.illegal}, 32'd1);
    cyc("fault hold", 1, 0, 4'h0, mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    @(negedge clock);
    clear         = 1'b1;
    bus.mem_ready = 1'b0;
    #1;
    check("clear illegal", {31'd0, bus.illegal}, 32'd0);
    check("clear state", {15'd0, outs()}, {15'd0, quiet});
    @(posedge clock);
    #2 clear = 1'b0;

    // Fetch stall: 16 not-ready cycles stay in FETCH, then FAULT.
    for (int i = 1; i <= 16; i++)
      cyc($sformatf("fetch stall%0d", i), 0, 0, 4'h0, f_idle);
    cyc("stall fault", 0, 0, 4'h0, mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check("stall illegal", {31'd0, bus.illegal}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clock  in  1  rising-edge system clock.
REQ-003 clear  in  1  async active-high reset.
REQ-004 opcode  in  4  instruction[15:12] from the instruction register.
REQ-005 eq  in  1  ALU equal flag for the current EXEC operands.
REQ-006 mem_ready  in  1  memory handshake; fetch or data access completes in the cycle it is 1.
REQ-007 imem_req  out  1  instruction fetch request.
REQ-008 ir_write  out  1  load the instruction register.
REQ-009 pc_write  out  1  update the PC.
REQ-010 pc_src  out  2  PC source: 00 = PC+2, 01 = branch target, 10 = jump target.
REQ-011 reg_dst  out  1  write register select: 1 = instruction[7:4], 0 = instruction[11:8].
REQ-012 reg_write, alu_src, mem_read, mem_write, mem_to_reg  out  1 each  datapath strobes.
REQ-013 alu_op  out  3  ALU function code.
REQ-014 state  out  3  current state encoding.
REQ-015 illegal  out  1  sticky fault flag.
REQ-016 retired  out  16  count of completed instructions.

Function
REQ-017 States and encodings SHALL be: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, FAULT = 5.
REQ-018 All outputs SHALL be a combinational decode of the state and the latched opcode; a strobe not listed for a state SHALL be 0.
REQ-019 FETCH SHALL behave as follows.
- imem_req = 1 while in FETCH.
- On mem_ready = 1: ir_write = 1, pc_write = 1, pc_src = 00, then go to DECODE.
- While mem_ready = 0: stay in FETCH.
REQ-020 The opcode SHALL be latched on the clock edge that leaves FETCH and held until the next fetch.
REQ-021 DECODE SHALL behave as follows.
- Legal opcodes are 0000 AND, 0001 OR, 0010 ADD, 0100 SLT, 0101 LW, 0110 SUB, 1010 SW, 1110 BNE, 1111 JMP.
- JMP: pc_write = 1, pc_src = 10, then go to FETCH and increment retired.
- Illegal opcode: go to FAULT.
- Any other legal opcode: go to EXEC.
REQ-022 alu_op SHALL be driven in EXEC and MEM with these codes.
- AND = 000, OR = 001, ADD = 010, SUB = 011, SLT = 111.
- LW and SW = 010; BNE = 011.
REQ-023 EXEC SHALL behave as follows.
- R-type: reg_dst = 1, alu_src = 0, then go to WB.
- LW/SW: alu_src = 1, then go to MEM.
- BNE: alu_src = 0; if eq = 0 then pc_write = 1 and pc_src = 01; go to FETCH and increment retired.
REQ-024 MEM SHALL behave as follows.
- LW: mem_read = 1 until mem_ready, then go to WB.
- SW: mem_write = 1 until mem_ready, then go to FETCH and increment retired.
REQ-025 WB SHALL assert reg_write = 1, with reg_dst = 1 for R-type and reg_dst = 0 and mem_to_reg = 1 for LW, then go to FETCH and increment retired.
REQ-026 With zero-wait memory, latency SHALL be: JMP 2, BNE 3, R-type 4, SW 4, LW 5 cycles.
REQ-027 A 4-bit wait counter SHALL count consecutive mem_ready = 0 cycles in FETCH or MEM and clear on mem_ready = 1 or on a state change.
REQ-028 When the wait counter reaches 15 with mem_ready still 0, the next state SHALL be FAULT.
REQ-029 FAULT SHALL set illegal = 1, drive all strobes 0, and stay in FAULT until clear.
REQ-030 retired SHALL be 16-bit unsigned and wrap from FFFF to 0000.
REQ-031 Any mem_ready pulse outside FETCH or MEM SHALL be ignored.

Reset
REQ-032 While clear = 1, the following SHALL hold, asynchronously, including mid-operation.
- state = FETCH, latched opcode = 0000, wait counter = 0, retired = 0, illegal = 0.
- All strobes = 0, pc_src = 00, alu_op = 000.
- imem_req is forced to 0.
REQ-033 The first fetch request SHALL appear in the first cycle after clear deasserts.

Structure
REQ-034 The shared package SHALL hold the state encodings, the opcode constants, the alu_op codes and the pc_src codes.
REQ-035 One sub-module, opcode_decoder, SHALL map opcode to a legal flag, an instruction class (R, LW, SW, BNE, JMP) and an alu_op.

Verification
REQ-036 Zero-wait ADD (0010), then SUB (0110): states 0,1,2,4 each, reg_write high in cycles 4 and 8, alu_op 010 then 011, retired = 2.
REQ-037 LW (0101) with mem_ready low for 3 MEM cycles: MEM held 4 cycles, mem_read high throughout, then WB with mem_to_reg = 1, reg_dst = 0.
REQ-038 BNE (1110) with eq = 0: pc_write = 1 and pc_src = 01 in EXEC; with eq = 1: pc_write = 0 in EXEC; both return to FETCH.
REQ-039 JMP (1111): pc_src = 10 in DECODE, next state FETCH; opcode 0011: FAULT, illegal = 1, strobes 0 until clear.
REQ-040 mem_ready held 0 in FETCH for 16 cycles: FAULT; retired preset to FFFF plus one SW retire: 0000.
REQ-041 clear asserted mid-MEM during SW: mem_write drops in the same cycle without a clock edge, state = 0, retired = 0.
